// File: rtl/loss_gradient_stage.sv
// loss_gradient_stage: per-unit error gradients, training strobe and batch squared-error loss.
// Define LOSS_MEAN_EN to report the batch mean instead of the raw sum (batch_size must be a power of two).
module loss_gradient_stage #(
  parameter int output_units = 2,
  parameter int batch_size = 4,
  parameter int sfp_w = 16,
  parameter int sfp_frac = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [output_units-1:0][sfp_w-1:0]  predictions,
  input  logic [output_units-1:0][sfp_w-1:0]  targets,
  input  logic                                train_en,
  output logic [output_units-1:0][sfp_w-1:0]  error_gradient,
  output logic                                grad_valid,
  output logic                                training,
  output logic [sfp_w-1:0]                    loss,
  output logic                                loss_valid,
  output logic [$clog2(batch_size):0]         sample_count
);
  localparam int CW = $clog2(batch_size) + 1;
  localparam int KW = output_units > 1 ? $clog2(output_units) : 1;
  typedef logic signed [sfp_w-1:0] sfp_t;
  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, REPORT} state_t;
  // Saturating signed fixed point, sfp_frac fractional bits.
  function automatic sfp_t sfp_sat(input logic signed [2*sfp_w-1:0] v);
    logic signed [2*sfp_w-1:0] mx, mn;
    mx = {{(sfp_w+1){1'b0}}, {(sfp_w-1){1'b1}}};
    mn = ~mx;
    return (v > mx) ? mx[sfp_w-1:0] : (v < mn) ? mn[sfp_w-1:0] : v[sfp_w-1:0];
  endfunction
  function automatic sfp_t sfp_add(input sfp_t a, input sfp_t b);
    logic signed [2*sfp_w-1:0] s;
    s = {{sfp_w{a[sfp_w-1]}}, a} + {{sfp_w{b[sfp_w-1]}}, b};
    return sfp_sat(s);
  endfunction
  function automatic sfp_t sfp_sub(input sfp_t a, input sfp_t b);
    logic signed [2*sfp_w-1:0] s;
    s = {{sfp_w{a[sfp_w-1]}}, a} - {{sfp_w{b[sfp_w-1]}}, b};
    return sfp_sat(s);
  endfunction
  function automatic sfp_t sfp_mul(input sfp_t a, input sfp_t b);
    logic signed [2*sfp_w-1:0] p;
    p = a * b;
    return sfp_sat(p >>> sfp_frac);
  endfunction
`ifdef LOSS_MEAN_EN
  if ((batch_size & (batch_size - 1)) != 0) begin : g_bad_batch
    $error("loss_gradient_stage: batch_size must be a power of two with LOSS_MEAN_EN");
  end
`endif
  state_t state_q;
  logic [KW-1:0] k_q;
  logic [output_units-1:0][sfp_w-1:0] pred_q, tgt_q, grad_q;
  logic te_q, gv_q, tr_q, lv_q;
  sfp_t acc_q, loss_q, diff_d, acc_d, loss_d;
  logic [CW-1:0] cnt_q;
  always_comb begin
    diff_d = sfp_sub(pred_q[k_q], tgt_q[k_q]);
    acc_d = sfp_add(acc_q, sfp_mul(diff_d, diff_d));
`ifdef LOSS_MEAN_EN
    loss_d = acc_q >>> $clog2(batch_size);
`else
    loss_d = acc_q;
`endif
  end
  // Strobes are set on entry to UPDATE/REPORT so they are high during those states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      pred_q <= '0;
      tgt_q <= '0;
      te_q <= 1'b0;
      grad_q <= '0;
      acc_q <= '0;
      loss_q <= '0;
      cnt_q <= '0;
      gv_q <= 1'b0;
      tr_q <= 1'b0;
      lv_q <= 1'b0;
    end else begin
      gv_q <= 1'b0;
      tr_q <= 1'b0;
      lv_q <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          pred_q <= predictions;
          tgt_q <= targets;
          te_q <= train_en;
          k_q <= '0;
          state_q <= ACCUM;
        end
        ACCUM: begin
          grad_q[k_q] <= diff_d;
          acc_q <= acc_d;
          if (k_q == KW'(output_units - 1)) begin
            state_q <= UPDATE;
            gv_q <= 1'b1;
            tr_q <= te_q;
            cnt_q <= cnt_q + 1'b1;
          end else k_q <= k_q + 1'b1;
        end
        UPDATE: if (cnt_q == CW'(batch_size)) begin
          state_q <= REPORT;
          loss_q <= loss_d;
          lv_q <= 1'b1;
        end else state_q <= IDLE;
        REPORT: begin
          acc_q <= '0;
          cnt_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign in_ready = state_q == IDLE;
  assign error_gradient = grad_q;
  assign grad_valid = gv_q;
  assign training = tr_q;
  assign loss = loss_q;
  assign loss_valid = lv_q;
  assign sample_count = cnt_q;
endmodule

// File: tb/tb_loss_gradient_stage.sv
// tb_loss_gradient_stage: directed vectors, scoreboard queues checked by a negedge monitor.
module tb_loss_gradient_stage;
  localparam int U = 2, B = 4, W = 16, CW = 3;
`ifdef LOSS_MEAN_EN
  localparam int LA = 100, LB = 64, LC = 20, LE = 64;
`else
  localparam int LA = 400, LB = 256, LC = 80, LE = 256;
`endif
  logic clk = 0, rst = 1, in_valid = 1, train_en = 0;
  logic in_ready, grad_valid, training, loss_valid;
  logic [U-1:0][W-1:0] predictions = '0, targets = '0, error_gradient;
  logic [W-1:0] loss;
  logic [CW-1:0] sample_count;
  int n_chk = 0, n_fail = 0, cyc = 0, last_hs = 0;
  typedef struct {int g0; int g1; bit tr; int cnt;} exp_t;
  exp_t gq[$];
  int lq[$];

  loss_gradient_stage #(.output_units(U), .batch_size(B)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .predictions(predictions), .targets(targets), .train_en(train_en),
    .error_gradient(error_gradient), .grad_valid(grad_valid), .training(training),
    .loss(loss), .loss_valid(loss_valid), .sample_count(sample_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int l;
    if (!rst) begin
      if (grad_valid) begin
        if (gq.size() == 0) chk("unexpected_grad_valid", 1, 0);
        else begin
          e = gq.pop_front();
          chk("grad0", $signed(error_gradient[0]), e.g0);
          chk("grad1", $signed(error_gradient[1]), e.g1);
          chk("training", int'(training), int'(e.tr));
          chk("sample_count", int'(sample_count), e.cnt);
        end
      end else if (training) chk("training_without_grad", 1, 0);
      if (loss_valid) begin
        if (lq.size() == 0) chk("unexpected_loss_valid", 1, 0);
        else begin
          l = lq.pop_front();
          chk("loss", $signed(loss), l);
          chk("count_at_report", int'(sample_count), B);
        end
      end
    end
  end

  task automatic send(input int p0, input int p1, input int t0, input int t1, input bit te,
                      input int g0, input int g1, input int cnt, input bit cont, input bit want);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    predictions[0] = 16'(p0);
    predictions[1] = 16'(p1);
    targets[0] = 16'(t0);
    targets[1] = 16'(t1);
    train_en = te;
    in_valid = 1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    if (want) begin
      e = '{g0, g1, te, cnt};
      gq.push_back(e);
    end
    @(posedge clk);
    #1;
    last_hs = cyc;
    if (!cont) in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs[5];
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_loss", int'(loss), 0);
    chk("rst_count", int'(sample_count), 0);
    chk("rst_strobes", int'({grad_valid, training, loss_valid}), 0);
    chk("rst_grad", int'(error_gradient), 0);
    rst = 0;
    in_valid = 0;
    // Batch A: latency, train_en=0 sample, loss report
    send(256, 128, 0, 128, 1, 256, 0, 1, 0, 1);
    @(posedge clk); #1;
    chk("gv_early", int'(grad_valid), 0);
    @(posedge clk); #1;
    chk("gv_cycle3", int'(grad_valid), 1);
    chk("tr_cycle3", int'(training), 1);
    chk("count_cycle3", int'(sample_count), 1);
    @(posedge clk); #1;
    chk("gv_one_cycle", int'(grad_valid), 0);
    send(128, 0, 0, 0, 1, 128, 0, 2, 0, 1);
    send(0, 0, 64, 0, 0, -64, 0, 3, 0, 1);
    lq.push_back(LA);
    send(0, 128, 0, 0, 1, 0, 128, 4, 0, 1);
    repeat (4) @(posedge clk); #1;
    chk("count_cleared", int'(sample_count), 0);
    chk("loss_held", $signed(loss), LA);
    chk("lv_one_cycle", int'(loss_valid), 0);
    // Batch B: fresh accumulator, unit errors of 0.5
    send(128, 0, 0, 0, 1, 128, 0, 1, 0, 1);
    send(0, 0, 128, 0, 0, -128, 0, 2, 0, 1);
    send(0, 128, 0, 0, 1, 0, 128, 3, 0, 1);
    lq.push_back(LB);
    send(0, 0, 0, 128, 1, 0, -128, 4, 0, 1);
    // Batch C plus first of D: in_valid held high throughout
    send(64, 0, 0, 0, 1, 64, 0, 1, 1, 1); hs[0] = last_hs;
    send(0, 64, 0, 0, 1, 0, 64, 2, 1, 1); hs[1] = last_hs;
    send(0, 0, 64, 0, 1, -64, 0, 3, 1, 1); hs[2] = last_hs;
    lq.push_back(LC);
    send(64, 64, 0, 0, 1, 64, 64, 4, 1, 1); hs[3] = last_hs;
    send(128, 0, 0, 0, 1, 128, 0, 1, 1, 1); hs[4] = last_hs;
    in_valid = 0;
    for (int i = 1; i < 5; i++) chk("accept_gap", hs[i] - hs[i-1], i == 4 ? 5 : 4);
    // Batch D: reset during ACCUM of third sample
    send(128, 0, 0, 0, 1, 128, 0, 2, 0, 1);
    send(0, 64, 0, 0, 1, 0, 0, 0, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_count", int'(sample_count), 0);
    chk("abort_grad", int'(error_gradient), 0);
    chk("abort_loss", int'(loss), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    // Batch E: reports only its own loss
    send(128, 0, 0, 0, 1, 128, 0, 1, 0, 1);
    send(0, 0, 128, 0, 1, -128, 0, 2, 0, 1);
    send(0, 128, 0, 0, 0, 0, 128, 3, 0, 1);
    lq.push_back(LE);
    send(0, 0, 0, 128, 1, 0, -128, 4, 0, 1);
    repeat (8) @(posedge clk); #1;
    chk("grad_queue_drained", gq.size(), 0);
    chk("loss_queue_drained", lq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
